// File: rtl/sfp_prbs_gen_chk.sv
// PRBS31 32-bit word generator and self-synchronising checker for the SFP0 GTH link.
// Single clock domain; the RX path is a two-stage pipeline feeding the lock FSM and status counters.
module sfp_prbs_gen_chk #(
  parameter int unsigned DW        = 32,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned LOCK_GOOD = 64,
  parameter int unsigned LOCK_BAD  = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             inject_err,
  input  logic             clr,
  output logic [DW-1:0]    tx_data,
  output logic             tx_valid,
  input  logic [DW-1:0]    rx_data,
  input  logic             rx_valid,
  output logic             locked,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int unsigned HW   = 31;
  localparam int unsigned TAP  = HW - 28;
  localparam int unsigned MW   = $clog2(DW + 1);
  localparam int unsigned RMAX = (LOCK_GOOD > LOCK_BAD) ? LOCK_GOOD : LOCK_BAD;
  localparam int unsigned RW   = $clog2(RMAX + 1);
  localparam int unsigned SW   = ((CNT_W > MW) ? CNT_W : MW) + 1;

  typedef enum logic {HUNT, LOCKED} state_t;

  // ---------------- generator ----------------
  logic [HW-1:0]    gen_hist;
  logic [HW+DW-1:0] gen_ext;

  // Serial recurrence unrolled over one word: history in the low bits, new bits above it.
  always_comb begin
    gen_ext = '0;
    gen_ext[HW-1:0] = gen_hist;
    for (int unsigned i = 0; i < DW; i++)
      gen_ext[HW+i] = gen_ext[i] ^ gen_ext[i+TAP];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gen_hist <= '1;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= en;
      if (en) begin
        gen_hist <= gen_ext[HW+DW-1:DW];
        tx_data  <= gen_ext[HW+DW-1:HW] ^ DW'(inject_err);
      end
    end
  end

  // ---------------- checker stage 1 ----------------
  logic [HW-1:0]    rx_hist;
  logic [HW+DW-1:0] chk_ext;
  logic [DW-1:0]    pred;
  logic [DW-1:0]    diff;
  logic [MW-1:0]    pop;
  logic [MW-1:0]    mism;
  logic             s1_valid;
  logic             s1_err;
  logic [MW-1:0]    s1_mism;

  always_comb begin
    chk_ext = '0;
    chk_ext[HW-1:0]     = rx_hist;
    chk_ext[HW+DW-1:HW] = rx_data;
    pred = '0;
    for (int unsigned i = 0; i < DW; i++)
      pred[i] = chk_ext[i] ^ chk_ext[i+TAP];
    diff = pred ^ rx_data;
    pop  = '0;
    for (int unsigned i = 0; i < DW; i++)
      pop = pop + MW'(diff[i]);
    // All-zero input predicts itself, so it is forced to a full-word error.
    mism = (rx_data == '0) ? MW'(DW) : pop;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_hist  <= '0;
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_mism  <= '0;
    end else begin
      s1_valid <= rx_valid;
      if (rx_valid) begin
        rx_hist <= rx_data[DW-1:DW-HW];
        s1_err  <= (mism != '0);
        s1_mism <= mism;
      end
    end
  end

  // ---------------- checker stage 2: lock FSM ----------------
  state_t        state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic          count_en;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= HUNT;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    count_en = 1'b0;
    if (s1_valid) begin
      case (state_q)
        HUNT: begin
          if (s1_err) begin
            run_d = '0;
          end else if (run_q == RW'(LOCK_GOOD - 1)) begin
            state_d = LOCKED;
            run_d   = '0;
          end else begin
            run_d = run_q + RW'(1);
          end
        end
        LOCKED: begin
          if (!s1_err) begin
            run_d    = '0;
            count_en = 1'b1;
          end else if (run_q == RW'(LOCK_BAD - 1)) begin
            state_d = HUNT;
            run_d   = '0;
          end else begin
            run_d    = run_q + RW'(1);
            count_en = 1'b1;
          end
        end
        default: begin
          state_d = HUNT;
          run_d   = '0;
        end
      endcase
    end
  end

  assign locked = (state_q == LOCKED);

  // ---------------- status counters ----------------
  logic [SW-1:0]    err_sum;
  logic [CNT_W-1:0] err_next;

  always_comb begin
    err_sum  = SW'(err_cnt) + SW'(s1_mism);
    err_next = (err_sum > SW'({CNT_W{1'b1}})) ? '1 : err_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_cnt    <= '0;
      word_cnt   <= '0;
      err_sticky <= 1'b0;
    end else if (clr) begin
      err_cnt    <= '0;
      word_cnt   <= '0;
      err_sticky <= 1'b0;
    end else if (count_en) begin
      err_cnt  <= err_next;
      word_cnt <= (word_cnt == '1) ? word_cnt : word_cnt + CNT_W'(1);
      if (s1_mism != '0)
        err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sfp_prbs_gen_chk.sv
// Directed bench for sfp_prbs_gen_chk: loopback lock, error injection, forced-zero
// input, async reset, valid gaps and a narrow-counter instance for saturation and clear.
module tb_sfp_prbs_gen_chk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, en, inject_err, clr;
  logic [31:0] tx_data, rx_data;
  logic        tx_valid, rx_valid, locked, err_sticky;
  logic [31:0] err_cnt, word_cnt;

  logic        lb;
  logic [31:0] rxd_force;
  logic        rxv_force;

  assign rx_data  = lb ? tx_data  : rxd_force;
  assign rx_valid = lb ? tx_valid : rxv_force;

  sfp_prbs_gen_chk #(.DW(32), .CNT_W(32), .LOCK_GOOD(64), .LOCK_BAD(8)) dut (
    .clk(clk), .resetn(resetn), .en(en), .inject_err(inject_err), .clr(clr),
    .tx_data(tx_data), .tx_valid(tx_valid), .rx_data(rx_data), .rx_valid(rx_valid),
    .locked(locked), .err_sticky(err_sticky), .err_cnt(err_cnt), .word_cnt(word_cnt)
  );

  logic        en4, clr4, zero4;
  logic [31:0] tx_data4, rx_data4;
  logic        tx_valid4, rx_valid4, locked4, err_sticky4;
  logic [3:0]  err_cnt4, word_cnt4;

  assign rx_data4  = zero4 ? 32'h0 : tx_data4;
  assign rx_valid4 = zero4 ? 1'b1  : tx_valid4;

  sfp_prbs_gen_chk #(.DW(32), .CNT_W(4), .LOCK_GOOD(64), .LOCK_BAD(8)) dut4 (
    .clk(clk), .resetn(resetn), .en(en4), .inject_err(1'b0), .clr(clr4),
    .tx_data(tx_data4), .tx_valid(tx_valid4), .rx_data(rx_data4), .rx_valid(rx_valid4),
    .locked(locked4), .err_sticky(err_sticky4), .err_cnt(err_cnt4), .word_cnt(word_cnt4)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0; en = 1'b0; inject_err = 1'b0; clr = 1'b0;
    lb = 1'b1; rxd_force = '0; rxv_force = 1'b0;
    en4 = 1'b0; clr4 = 1'b0; zero4 = 1'b0;

    // reset state, then idle with en=0
    cyc(3);
    chk("reset_state", {tx_data, tx_valid, locked, err_sticky, err_cnt, word_cnt}, '0);
    resetn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      chk("idle", {tx_data, tx_valid, locked, err_sticky, err_cnt, word_cnt}, '0);
    end

    // loopback: first three words from the all-ones state, then lock timing
    en = 1'b1;
    cyc(1);
    chk("tx_word0", tx_data, 32'h7000_0000);
    chk("tx_valid", tx_valid, 1'b1);
    cyc(1);
    chk("tx_word1", tx_data, 32'h3F00_0000);
    cyc(1);
    chk("tx_word2", tx_data, 32'h1C70_0000);
    cyc(63);
    chk("lock_early", locked, 1'b0);
    cyc(1);
    chk("lock_rise", locked, 1'b1);
    chk("lock_word_cnt", word_cnt, 32'd0);
    cyc(1000);
    chk("lb_word_cnt", word_cnt, 32'd1000);
    chk("lb_err_cnt", err_cnt, 32'd0);
    chk("lb_sticky", err_sticky, 1'b0);

    // single injected bit error -> 3 mismatches in one word
    inject_err = 1'b1;
    cyc(1);
    inject_err = 1'b0;
    cyc(1);
    chk("inj_latency", err_cnt, 32'd0);
    cyc(1);
    chk("inj_err_cnt", err_cnt, 32'd3);
    chk("inj_sticky", err_sticky, 1'b1);
    chk("inj_locked", locked, 1'b1);
    cyc(20);
    chk("inj_err_hold", err_cnt, 32'd3);
    chk("inj_lock_hold", locked, 1'b1);

    // clear
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr_err", err_cnt, 32'd0);
    chk("clr_word", word_cnt, 32'd0);
    chk("clr_sticky", err_sticky, 1'b0);
    cyc(5);
    chk("post_clr_word", word_cnt, 32'd5);

    // eight all-zero words drop lock; the eighth is not counted
    lb = 1'b0; rxd_force = '0; rxv_force = 1'b1;
    cyc(8);
    chk("zero_err_cnt", err_cnt, 32'd224);
    chk("zero_still_locked", locked, 1'b1);
    rxv_force = 1'b0;
    cyc(1);
    chk("zero_unlock", locked, 1'b0);
    chk("zero_err_final", err_cnt, 32'd224);
    chk("zero_word_final", word_cnt, 32'd13);

    // asynchronous reset mid-run
    #2 resetn = 1'b0;
    #1 chk("async_rst", {tx_data, tx_valid, locked, err_sticky, err_cnt, word_cnt}, '0);
    en = 1'b0;
    cyc(2);
    resetn = 1'b1;

    // constant zero input from reset never locks
    rxv_force = 1'b1; rxd_force = '0;
    for (int i = 0; i < 200; i++) begin
      cyc(1);
      chk("zero_no_lock", locked, 1'b0);
    end
    chk("zero_no_count", err_cnt, 32'd0);
    chk("zero_no_sticky", err_sticky, 1'b0);

    // loopback with valid every other cycle
    resetn = 1'b0;
    rxv_force = 1'b0;
    cyc(2);
    resetn = 1'b1;
    lb = 1'b1;
    for (int i = 0; i <= 331; i++) begin
      en = (i % 2 == 0);
      cyc(1);
      if (i == 129) chk("gap_lock_early", locked, 1'b0);
      if (i == 130) chk("gap_lock_rise", locked, 1'b1);
      if (i == 330) chk("gap_word_cnt", word_cnt, 32'd100);
      if (i == 331) begin
        chk("gap_word_hold", word_cnt, 32'd100);
        chk("gap_err_cnt", err_cnt, 32'd0);
      end
    end
    en = 1'b0;

    // narrow counters: saturation and clear priority
    resetn = 1'b0;
    cyc(2);
    resetn = 1'b1;
    en4 = 1'b1;
    cyc(67);
    chk("c4_locked", locked4, 1'b1);
    cyc(20);
    chk("c4_word_sat", word_cnt4, 4'd15);
    chk("c4_err_zero", err_cnt4, 4'd0);
    zero4 = 1'b1;
    cyc(1);
    clr4 = 1'b1;
    cyc(1);
    clr4 = 1'b0;
    zero4 = 1'b0;
    chk("c4_clr_err", err_cnt4, 4'd0);
    chk("c4_clr_sticky", err_sticky4, 1'b0);
    chk("c4_clr_word", word_cnt4, 4'd0);
    cyc(1);
    chk("c4_err_sat", err_cnt4, 4'd15);
    chk("c4_sticky", err_sticky4, 1'b1);
    chk("c4_word_one", word_cnt4, 4'd1);
    chk("c4_still_locked", locked4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
